pattern_match_ctrl: RTL and testbench

//  Run-time programmable serial pattern detector controller. Replaces fixed-pattern
//  one-hot detector FSMs: software loads a pattern of 1..MAX_LEN bits, arms the block,
//  and it scans a qualified serial bit stream. It counts matches and stops after a

---
 rtl/pattern_match_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_pattern_match_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_match_ctrl.sv
// pattern_match_ctrl
//   Run-time programmable serial pattern detector. Software loads a pattern of
//   1..MAX_LEN bits through a valid/ready config port, arms the block with
//   start, and the block scans a qualified serial stream. Every hit pulses
//   match and bumps a saturating counter. Once a non-zero target hit count is
//   reached, the block parks in DONE until it is re-armed or sent back to IDLE.
//
//   History is a shift register with the newest bit in the LSB. A fill counter
//   tracks how many valid bits have arrived since arming (or since the last
//   hit when overlap is disabled), so that stale history can never complete a
//   pattern.
module pattern_match_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  // Width of the length field. The fill counter shares it because fill never
  // exceeds MAX_LEN, and MAX_LEN always fits in the length field.
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_n;

  // Stored configuration.
  logic [MAX_LEN-1:0] pat_q, pat_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic               ovl_q, ovl_n;
  logic [CNT_W-1:0]   tgt_q, tgt_n;

  // Scan state.
  logic [MAX_LEN-1:0] hist_q, hist_n;
  logic [LEN_W-1:0]   fill_q, fill_n;
  logic [CNT_W-1:0]   count_n;

  // Next values of the registered pulse outputs.
  logic match_n;
  logic cfg_err_n;

  // Helper terms for the scan datapath.
  logic               cfg_fire;
  logic [MAX_LEN-1:0] shift_hist;
  logic [LEN_W-1:0]   shift_fill;
  logic [CNT_W-1:0]   count_inc;
  logic               hit;

  // Mask that selects the low 'len' bits of the history and the pattern.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // A length can be armed only if it is in 1..MAX_LEN.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_LEN));
  endfunction

  assign cfg_fire   = cfg_valid && cfg_ready;
  assign shift_hist = {hist_q[MAX_LEN-2:0], data_in};
  assign shift_fill = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
  assign count_inc  = (match_count == '1) ? match_count : match_count + CNT_W'(1);

  // A hit needs at least 'len' fresh bits and agreement on the low 'len' bits.
  assign hit = (shift_fill >= len_q) &&
               (((shift_hist ^ pat_q) & len_mask(len_q)) == '0);

  // Next-state, next-config and next-output decisions of the controller.
  always_comb begin
    // NOTE: every variable gets its default first, so no path through the
    // case statement leaves one unassigned and no latch can be inferred.
    state_n   = state_q;
    pat_n     = pat_q;
    len_n     = len_q;
    ovl_n     = ovl_q;
    tgt_n     = tgt_q;
    hist_n    = hist_q;
    fill_n    = fill_q;
    count_n   = match_count;
    match_n   = 1'b0;
    cfg_err_n = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A config accepted in the same cycle as start is what start is
        // checked against, so the latch happens before the start decision.
        if (cfg_fire) begin
          pat_n = cfg_pattern;
          len_n = cfg_len;
          ovl_n = cfg_overlap;
          tgt_n = cfg_target;
        end

        if (abort) begin
          state_n = S_IDLE;
        end else if (start && len_legal(len_n)) begin
          state_n = S_ARMED;
          count_n = '0;
          hist_n  = '0;
          fill_n  = '0;
        end else begin
          if (start) begin
            cfg_err_n = 1'b1;
          end
          // A new config while parked in DONE drops the block back to IDLE.
          if (cfg_fire) begin
            state_n = S_IDLE;
          end
        end
      end

      S_ARMED: begin
        if (abort) begin
          // Any hit completed in this cycle is discarded; the count is kept.
          state_n = S_IDLE;
        end else if (data_valid) begin
          hist_n = shift_hist;
          fill_n = shift_fill;
          if (hit) begin
            match_n = 1'b1;
            count_n = count_inc;
            // Without overlap the next hit must be built from fresh bits only.
            if (!ovl_q) begin
              fill_n = '0;
            end
            if ((tgt_q != '0) && (count_inc == tgt_q)) begin
              state_n = S_DONE;
            end
          end
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, configuration, scan history and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the stored config is reset as well, so the block comes up with
      // len=0 and a start before any config write is rejected.
      state_q     <= S_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      match_count <= '0;
      match       <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_n;
      pat_q       <= pat_n;
      len_q       <= len_n;
      ovl_q       <= ovl_n;
      tgt_q       <= tgt_n;
      hist_q      <= hist_n;
      fill_q      <= fill_n;
      match_count <= count_n;
      match       <= match_n;
      cfg_err     <= cfg_err_n;
      cfg_ready   <= (state_n != S_ARMED);
      busy        <= (state_n == S_ARMED);
      done        <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Testbench for pattern_match_ctrl. A behavioural model keeps the received
// bits in a queue and decides hits by comparing the queue tail with the
// pattern. Inputs change on the falling edge, and outputs are compared on the
// following falling edge.
module tb_pattern_match_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int OUT_W   = CNT_W + 5;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DONE  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [3:0]         cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               data_valid = 1'b0;
  logic               data_in = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;
  logic               cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pattern_match_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  wire [OUT_W-1:0] outs = {cfg_ready, match, match_count, busy, done, cfg_err};
  localparam logic [OUT_W-1:0] RESET_OUTS = {1'b1, {(OUT_W-1){1'b0}}};

  // ---------------- behavioural reference model ----------------
  int               m_state;
  logic [MAX_LEN-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  int               m_tgt;
  int               m_count;
  bit               m_match;
  bit               m_err;
  bit               bits[$];

  task automatic model_reset();
    m_state = M_IDLE; m_pat = '0; m_len = 0; m_ovl = 0; m_tgt = 0;
    m_count = 0; m_match = 0; m_err = 0; bits.delete();
  endtask

  // True when the newest m_len received bits spell the pattern,
  // pattern bit 0 being the newest bit.
  function automatic bit tail_matches();
    if (bits.size() < m_len) return 0;
    for (int i = 0; i < m_len; i++) begin
      if (bits[bits.size() - 1 - i] != m_pat[i]) return 0;
    end
    return 1;
  endfunction

  task automatic model_step();
    bit fire;
    fire    = cfg_valid && (m_state != M_ARMED);
    m_match = 0;
    m_err   = 0;
    if (m_state == M_ARMED) begin
      if (abort) begin
        m_state = M_IDLE;
      end else if (data_valid) begin
        bits.push_back(data_in);
        if (bits.size() > MAX_LEN) void'(bits.pop_front());
        if (tail_matches()) begin
          m_match = 1;
          if (m_count < (1 << CNT_W) - 1) m_count++;
          if (!m_ovl) bits.delete();
          if (m_tgt != 0 && m_count == m_tgt) m_state = M_DONE;
        end
      end
    end else begin
      if (fire) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len);
        m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
      end
      if (abort) begin
        m_state = M_IDLE;
      end else if (start && m_len >= 1 && m_len <= MAX_LEN) begin
        m_state = M_ARMED; m_count = 0; bits.delete();
      end else begin
        if (start) m_err = 1;
        if (fire) m_state = M_IDLE;
      end
    end
  endtask

  function automatic logic [OUT_W-1:0] exp_outs();
    return {m_state != M_ARMED, m_match, CNT_W'(m_count),
            m_state == M_ARMED, m_state == M_DONE, m_err};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    cfg_valid = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic set_cfg(input logic [MAX_LEN-1:0] p, input int len,
                         input bit ovl, input int tgt);
    cfg_valid   = 1'b1;
    cfg_pattern = p;
    cfg_len     = 4'(len);
    cfg_overlap = ovl;
    cfg_target  = CNT_W'(tgt);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if (outs !== RESET_OUTS) begin
      n_fail++; $display("FAIL reset_initial: got %h expected %h", outs, RESET_OUTS);
    end
    set_cfg(8'b1, 1, 1, 0); start = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1; data_in = 1'b1; tick();
    end
    n_checks++;
    if (busy !== 1'b1 || match_count !== 8'd3) begin
      n_fail++; $display("FAIL reset_preamble: busy=%b count=%0d expected busy=1 count=3", busy, match_count);
    end
    // Assert reset between edges while a hit is still being produced.
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (outs !== RESET_OUTS) begin
      n_fail++; $display("FAIL reset_async: got %h expected %h", outs, RESET_OUTS);
    end
    tick();
    n_checks++;
    if (outs !== RESET_OUTS) begin
      n_fail++; $display("FAIL reset_held: got %h expected %h", outs, RESET_OUTS);
    end
    rst = 1'b0; data_valid = 1'b0;
    tick();
    // Start with no config since reset must be rejected.
    start = 1'b1; tick();
    n_checks++;
    if (outs !== exp_outs() || cfg_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_rejected: got %h expected %h", outs, exp_outs());
    end
    tick();
    n_checks++;
    if (cfg_err !== 1'b0 || outs !== exp_outs()) begin
      n_fail++; $display("FAIL reset_err_pulse: cfg_err=%b expected 0", cfg_err);
    end
  endtask

  task automatic run_010(input bit ovl, input string tag, output int pulses);
    bit s[5] = '{0, 1, 0, 1, 0};
    pulses = 0;
    // Config and start in the same cycle: start is judged on the new config.
    set_cfg(8'b010, 3, ovl, 0); start = 1'b1; tick();
    n_checks++;
    if (outs !== exp_outs() || busy !== 1'b1) begin
      n_fail++; $display("FAIL %s_arm: got %h expected %h", tag, outs, exp_outs());
    end
    for (int i = 0; i < 6; i++) begin
      data_valid = (i < 5); data_in = (i < 5) ? s[i] : 1'b0;
      tick();
      pulses += int'(match);
      n_checks++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL %s_bit%0d: got %h expected %h", tag, i, outs, exp_outs());
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_overlap_on();
    int pulses;
    run_010(1'b1, "ovl_on", pulses);
    n_checks++;
    if (pulses != 2 || match_count !== 8'd2) begin
      n_fail++; $display("FAIL ovl_on_total: pulses=%0d count=%0d expected 2/2", pulses, match_count);
    end
    abort = 1'b1; tick();
  endtask

  task automatic test_overlap_off();
    int pulses;
    run_010(1'b0, "ovl_off", pulses);
    n_checks++;
    if (pulses != 1 || match_count !== 8'd1) begin
      n_fail++; $display("FAIL ovl_off_total: pulses=%0d count=%0d expected 1/1", pulses, match_count);
    end
    abort = 1'b1; tick();
  endtask

  task automatic test_target();
    int pulses = 0;
    set_cfg(8'b11, 2, 1, 3); start = 1'b1; tick();
    for (int i = 0; i < 6; i++) begin
      data_valid = 1'b1; data_in = 1'b1; tick();
      pulses += int'(match);
      n_checks++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL target_bit%0d: got %h expected %h", i, outs, exp_outs());
      end
    end
    data_valid = 1'b0;
    n_checks++;
    if (pulses != 3 || match_count !== 8'd3 || done !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL target_done: pulses=%0d count=%0d done=%b ready=%b expected 3/3/1/1",
                         pulses, match_count, done, cfg_ready);
    end
  endtask

  task automatic test_gaps();
    bit s[3] = '{0, 1, 0};
    int pulses = 0;
    int k = 0;
    int pulse_at = -1;
    set_cfg(8'b010, 3, 1, 0); start = 1'b1; tick();
    for (int i = 0; i < 7; i++) begin
      data_valid = (i % 3 == 0) && (k < 3);
      data_in    = data_valid ? s[k] : ~s[k % 3];
      if (data_valid) k++;
      tick();
      if (match) begin pulses++; pulse_at = i; end
      n_checks++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL gaps_cyc%0d: got %h expected %h", i, outs, exp_outs());
      end
    end
    data_valid = 1'b0;
    // Last valid bit is driven in cycle 6; the pulse appears right after it.
    n_checks++;
    if (pulses != 1 || pulse_at != 6) begin
      n_fail++; $display("FAIL gaps_pulse: pulses=%0d at=%0d expected 1 at 6", pulses, pulse_at);
    end
  endtask

  task automatic test_abort();
    abort = 1'b1; tick();
    set_cfg(8'b1, 1, 0, 0); start = 1'b1; tick();
    data_valid = 1'b1; data_in = 1'b1; tick(); tick();
    data_valid = 1'b0;
    abort = 1'b1; start = 1'b1; tick();
    n_checks++;
    if (busy !== 1'b0 || match_count !== 8'd2 || outs !== exp_outs()) begin
      n_fail++; $display("FAIL abort_start: busy=%b count=%0d expected busy=0 count=2", busy, match_count);
    end
    start = 1'b1; tick();
    n_checks++;
    if (busy !== 1'b1 || match_count !== 8'd0 || outs !== exp_outs()) begin
      n_fail++; $display("FAIL abort_rearm: busy=%b count=%0d expected busy=1 count=0", busy, match_count);
    end
    data_valid = 1'b1; data_in = 1'b1; abort = 1'b1; tick();
    data_valid = 1'b0;
    n_checks++;
    if (match !== 1'b0 || match_count !== 8'd0 || busy !== 1'b0 || outs !== exp_outs()) begin
      n_fail++; $display("FAIL abort_hit_dropped: match=%b count=%0d expected 0/0", match, match_count);
    end
  endtask

  task automatic test_saturation();
    set_cfg(8'b1, 1, 1, 0); start = 1'b1; tick();
    data_valid = 1'b1; data_in = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    n_checks++;
    if (match_count !== 8'hFF || match !== 1'b1 || outs !== exp_outs()) begin
      n_fail++; $display("FAIL saturation: count=%0d match=%b expected 255/1", match_count, match);
    end
    data_valid = 1'b0;
    abort = 1'b1; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_cfg(MAX_LEN'($urandom), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15)
                                                               : $urandom_range(1, 3),
                1'($urandom), $urandom_range(0, 4));
      end
      start      = ($urandom_range(0, 9) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      data_valid = ($urandom_range(0, 3) != 0);
      data_in    = 1'($urandom);
      tick();
      n_checks++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL random_cyc%0d: got %h expected %h", i, outs, exp_outs());
      end
    end
    data_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_overlap_on();
    test_overlap_off();
    test_target();
    test_gaps();
    test_abort();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
